// File: rtl/vcfg_pipe_if.sv
// Handshake, rd-writeback response and architectural vl/vtype/vlmax view shared by
// the scalar issue stage (master) and the vector configuration unit (slave).
interface vcfg_pipe_if #(
  parameter int XLEN    = 32,
  parameter int VL_BITS = 15
);
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        insn;
  logic [XLEN-1:0]    rs1_val;
  logic [XLEN-1:0]    rs2_val;
  logic               out_valid;
  logic               out_ready;
  logic [4:0]         out_rd_addr;
  logic               out_rd_we;
  logic [XLEN-1:0]    out_rd_data;
  logic [VL_BITS-1:0] vl;
  logic [XLEN-1:0]    vtype;
  logic [VL_BITS-1:0] vlmax;

  modport master (
    output in_valid, insn, rs1_val, rs2_val, out_ready,
    input  in_ready, out_valid, out_rd_addr, out_rd_we, out_rd_data, vl, vtype, vlmax
  );

  modport slave (
    input  in_valid, insn, rs1_val, rs2_val, out_ready,
    output in_ready, out_valid, out_rd_addr, out_rd_we, out_rd_data, vl, vtype, vlmax
  );
endinterface

// File: rtl/vcfg_pipe.sv
// Vector configuration unit: executes vsetvli/vsetivli/vsetvl through an IDLE/CALC/RESP
// pipeline and holds the architectural vl, vtype and vlmax state.
module vcfg_pipe #(
  parameter int XLEN             = 32,
  parameter int VLEN             = 16384,
  parameter int ELEN             = 64,
  parameter int VL_BITS          = $clog2(VLEN) + 1,
  parameter bit ENABLE_FRAC_LMUL = 1'b1,
  parameter bit ALLOW_VMA        = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  vcfg_pipe_if.slave bus
);

  localparam int                 CW         = (XLEN > VL_BITS) ? XLEN : VL_BITS;
  localparam logic [3:0]         ELEN_LOG2  = (ELEN == 64) ? 4'd6 : 4'd5;
  localparam logic [XLEN-1:0]    VTYPE_VILL = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [VL_BITS-1:0] VLEN_W     = VL_BITS'(VLEN);
  localparam logic [6:0]         OP_V       = 7'b1010111;
  localparam logic [2:0]         F3_CFG     = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        insn_q, insn_d;
  logic [XLEN-1:0]    rs1_q, rs1_d;
  logic [XLEN-1:0]    rs2_q, rs2_d;
  logic [VL_BITS-1:0] vl_q, vl_d;
  logic [XLEN-1:0]    vtype_q, vtype_d;
  logic [VL_BITS-1:0] vlmax_q, vlmax_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [4:0]         out_rd_addr_q, out_rd_addr_d;
  logic               out_rd_we_q, out_rd_we_d;
  logic [XLEN-1:0]    out_rd_data_q, out_rd_data_d;

  logic               base_ok_s, is_vli_s, is_ivli_s, is_vl_s, is_cfg_s;
  logic               frac_s, keep_vl_s, ill_s;
  logic [4:0]         rd_s, rs1_idx_s;
  logic [XLEN-1:0]    cand_s;
  logic [2:0]         vlmul_s, vsew_s, frac_sh_s;
  logic [3:0]         sew_log2_s;
  logic [VL_BITS-1:0] base_s, vlmax_new_s, vl_new_s;
  logic [CW-1:0]      avl_s;

  // Decode the latched instruction and derive candidate vtype, VLMAX, AVL and vl.
  always_comb begin
    rd_s      = insn_q[11:7];
    rs1_idx_s = insn_q[19:15];
    base_ok_s = (insn_q[6:0] == OP_V) && (insn_q[14:12] == F3_CFG);
    is_vli_s  = base_ok_s && (insn_q[31] == 1'b0);
    is_ivli_s = base_ok_s && (insn_q[31:30] == 2'b11);
    is_vl_s   = base_ok_s && (insn_q[31:25] == 7'b1000000);
    is_cfg_s  = is_vli_s || is_ivli_s || is_vl_s;

    if (is_ivli_s) begin
      cand_s = {{(XLEN-10){1'b0}}, insn_q[29:20]};
    end else if (is_vli_s) begin
      cand_s = {{(XLEN-11){1'b0}}, insn_q[30:20]};
    end else begin
      cand_s = rs2_q;
    end

    vlmul_s    = cand_s[2:0];
    vsew_s     = cand_s[5:3];
    sew_log2_s = {1'b0, vsew_s} + 4'd3;
    frac_s     = vlmul_s[2];
    // mf8/mf4/mf2 (101/110/111) divide by 2^(4 - vlmul[1:0]).
    frac_sh_s  = 3'd4 - {1'b0, vlmul_s[1:0]};
    base_s     = VLEN_W >> sew_log2_s;
    if (frac_s) begin
      vlmax_new_s = base_s >> frac_sh_s;
    end else begin
      vlmax_new_s = base_s << vlmul_s[1:0];
    end

    keep_vl_s = 1'b0;
    if (is_ivli_s) begin
      avl_s = CW'(insn_q[19:15]);
    end else if (rs1_idx_s != 5'd0) begin
      avl_s = CW'(rs1_q);
    end else if (rd_s != 5'd0) begin
      avl_s = {CW{1'b1}};
    end else begin
      avl_s     = CW'(vl_q);
      keep_vl_s = 1'b1;
    end

    ill_s = cand_s[XLEN-1] || (|cand_s[XLEN-2:8]) || vsew_s[2]
         || (sew_log2_s > ELEN_LOG2) || (vlmul_s == 3'b100)
         || (frac_s && !ENABLE_FRAC_LMUL)
         || (frac_s && ((sew_log2_s + {1'b0, frac_sh_s}) > ELEN_LOG2))
         || (cand_s[7] && !ALLOW_VMA)
         || (keep_vl_s && (vlmax_new_s != vlmax_q));

    // Compare at full width so large AVLs saturate instead of wrapping.
    if (ill_s) begin
      vl_new_s = {VL_BITS{1'b0}};
    end else if (avl_s < CW'(vlmax_new_s)) begin
      vl_new_s = avl_s[VL_BITS-1:0];
    end else begin
      vl_new_s = vlmax_new_s;
    end
  end

  // Next-state, commit and response-register logic for the three-state pipeline.
  always_comb begin
    state_d       = state_q;
    insn_d        = insn_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    vl_d          = vl_q;
    vtype_d       = vtype_q;
    vlmax_d       = vlmax_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    out_rd_addr_d = out_rd_addr_q;
    out_rd_we_d   = out_rd_we_q;
    out_rd_data_d = out_rd_data_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          insn_d     = bus.insn;
          rs1_d      = bus.rs1_val;
          rs2_d      = bus.rs2_val;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      CALC: begin
        if (is_cfg_s && ill_s) begin
          vl_d    = {VL_BITS{1'b0}};
          vtype_d = VTYPE_VILL;
          vlmax_d = {VL_BITS{1'b0}};
        end else if (is_cfg_s) begin
          vl_d    = vl_new_s;
          vtype_d = cand_s;
          vlmax_d = vlmax_new_s;
        end else begin
          vl_d    = vl_q;
          vtype_d = vtype_q;
          vlmax_d = vlmax_q;
        end
        out_rd_addr_d = rd_s;
        out_rd_we_d   = is_cfg_s && (rd_s != 5'd0);
        out_rd_data_d = is_cfg_s ? XLEN'(vl_new_s) : XLEN'(vl_q);
        out_valid_d   = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      insn_q        <= 32'd0;
      rs1_q         <= {XLEN{1'b0}};
      rs2_q         <= {XLEN{1'b0}};
      vl_q          <= {VL_BITS{1'b0}};
      vtype_q       <= VTYPE_VILL;
      vlmax_q       <= {VL_BITS{1'b0}};
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_rd_addr_q <= 5'd0;
      out_rd_we_q   <= 1'b0;
      out_rd_data_q <= {XLEN{1'b0}};
    end else begin
      state_q       <= state_d;
      insn_q        <= insn_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      vl_q          <= vl_d;
      vtype_q       <= vtype_d;
      vlmax_q       <= vlmax_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_rd_addr_q <= out_rd_addr_d;
      out_rd_we_q   <= out_rd_we_d;
      out_rd_data_q <= out_rd_data_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_rd_addr = out_rd_addr_q;
  assign bus.out_rd_we   = out_rd_we_q;
  assign bus.out_rd_data = out_rd_data_q;
  assign bus.vl          = vl_q;
  assign bus.vtype       = vtype_q;
  assign bus.vlmax       = vlmax_q;

endmodule

// File: tb/tb_vcfg_pipe.sv
// Randomised and directed bench for vcfg_pipe against a rational-arithmetic model of
// the vector configuration rules.
module tb_vcfg_pipe;
  localparam int          XLEN    = 32;
  localparam int          VLEN    = 16384;
  localparam int          ELEN    = 64;
  localparam int          VL_BITS = 15;
  localparam bit          FRAC    = 1'b1;
  localparam bit          VMA     = 1'b0;
  localparam logic [31:0] VILL    = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  longint      m_vl, m_vlmax;
  logic [31:0] m_vtype, m_data;
  bit          m_we, m_cfg;

  always #5 clk = ~clk;

  vcfg_pipe_if #(.XLEN(XLEN), .VL_BITS(VL_BITS)) bus ();

  vcfg_pipe #(
    .XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN), .VL_BITS(VL_BITS),
    .ENABLE_FRAC_LMUL(FRAC), .ALLOW_VMA(VMA)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  function automatic logic [31:0] enc_vli(input logic [4:0] rd, input logic [4:0] rs1, input logic [10:0] z);
    return {1'b0, z, rs1, 3'b111, rd, 7'b1010111};
  endfunction

  function automatic logic [31:0] enc_ivli(input logic [4:0] rd, input logic [4:0] uimm, input logic [9:0] z);
    return {2'b11, z, uimm, 3'b111, rd, 7'b1010111};
  endfunction

  function automatic logic [31:0] enc_vl(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b1000000, rs2, rs1, 3'b111, rd, 7'b1010111};
  endfunction

  task automatic model_reset();
    m_vl = 0; m_vlmax = 0; m_vtype = VILL;
  endtask

  // LMUL as num/den; VLMAX = VLEN*LMUL/SEW; legality SEW <= ELEN*LMUL.
  task automatic model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    bit vli, ivli, vlk, ok;
    logic [31:0] cand;
    logic [4:0] rd, rs1;
    int vsew, vlmul, sew, num, den;
    longint vmax, avl;
    rd   = i[11:7];
    rs1  = i[19:15];
    vli  = (i[6:0] == 7'h57) && (i[14:12] == 3'b111) && (i[31] == 1'b0);
    ivli = (i[6:0] == 7'h57) && (i[14:12] == 3'b111) && (i[31:30] == 2'b11);
    vlk  = (i[6:0] == 7'h57) && (i[14:12] == 3'b111) && (i[31:25] == 7'b1000000);
    m_cfg = vli || ivli || vlk;
    m_we  = m_cfg && (rd != 5'd0);
    if (m_cfg) begin
      cand  = ivli ? {22'd0, i[29:20]} : (vli ? {21'd0, i[30:20]} : b);
      vsew  = int'(cand[5:3]);
      vlmul = int'(cand[2:0]);
      sew   = 8 << vsew;
      num = 1; den = 1; ok = 1'b1;
      case (vlmul)
        0, 1, 2, 3: num = 1 << vlmul;
        4:          ok = 1'b0;
        default:    den = 1 << (8 - vlmul);
      endcase
      if (cand[31] || (cand[30:8] != 23'd0) || vsew > 3 || sew > ELEN || (den > 1 && !FRAC)
          || sew * den > ELEN * num || (cand[7] && !VMA)) ok = 1'b0;
      vmax = ok ? (longint'(VLEN) * num) / (sew * den) : 0;
      if (ivli) avl = longint'(rs1);
      else if (rs1 != 5'd0) avl = longint'(a);
      else if (rd != 5'd0) avl = 64'h0000_0000_FFFF_FFFF;
      else begin
        avl = m_vl;
        if (vmax != m_vlmax) ok = 1'b0;
      end
      if (ok) begin
        m_vtype = cand; m_vlmax = vmax; m_vl = (avl < vmax) ? avl : vmax;
      end else begin
        m_vtype = VILL; m_vlmax = 0; m_vl = 0;
      end
    end
    m_data = m_vl[31:0];
  endtask

  // Issue one instruction; returns cycles from accept edge to out_valid (expected 2).
  task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    bus.in_valid = 1'b1; bus.insn = i; bus.rs1_val = a; bus.rs2_val = b;
    model(i, a, b);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.insn = $urandom; bus.rs1_val = $urandom; bus.rs2_val = $urandom;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic respond(input int hold);
    for (int k = 0; k < hold; k++) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_rd_we !== 1'b0) begin bad++; $display("FAIL rst_rd_we: got %b want 0", bus.out_rd_we); end
    total++; if (bus.out_rd_addr !== 5'd0) begin bad++; $display("FAIL rst_rd_addr: got %0d want 0", bus.out_rd_addr); end
    total++; if (bus.out_rd_data !== 32'd0) begin bad++; $display("FAIL rst_rd_data: got %0h want 0", bus.out_rd_data); end
    total++; if (bus.vl !== 15'd0) begin bad++; $display("FAIL rst_vl: got %0d want 0", bus.vl); end
    total++; if (bus.vtype !== VILL) begin bad++; $display("FAIL rst_vtype: got %h want %h", bus.vtype, VILL); end
    total++; if (bus.vlmax !== 15'd0) begin bad++; $display("FAIL rst_vlmax: got %0d want 0", bus.vlmax); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_vsetvli();
    int lat;
    send(enc_vli(5'd1, 5'd5, 11'h010), 32'd100, 32'd0, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL basic_latency: got %0d want 2", lat); end
    total++; if (bus.out_rd_data !== 32'd100) begin bad++; $display("FAIL basic_data: got %0d want 100", bus.out_rd_data); end
    total++; if (bus.out_rd_we !== 1'b1) begin bad++; $display("FAIL basic_we: got %b want 1", bus.out_rd_we); end
    total++; if (bus.out_rd_addr !== 5'd1) begin bad++; $display("FAIL basic_addr: got %0d want 1", bus.out_rd_addr); end
    total++; if (bus.vl !== 15'd100) begin bad++; $display("FAIL basic_vl: got %0d want 100", bus.vl); end
    total++; if (bus.vlmax !== 15'd512) begin bad++; $display("FAIL basic_vlmax: got %0d want 512", bus.vlmax); end
    total++; if (bus.vtype !== 32'h10) begin bad++; $display("FAIL basic_vtype: got %h want 10", bus.vtype); end
    respond(0);
    send(enc_vli(5'd2, 5'd6, 11'h003), 32'd5000, 32'd0, lat);
    total++; if (bus.vl !== 15'd5000) begin bad++; $display("FAIL m8_vl5000: got %0d want 5000", bus.vl); end
    total++; if (bus.vlmax !== 15'd16384) begin bad++; $display("FAIL m8_vlmax: got %0d want 16384", bus.vlmax); end
    respond(0);
    send(enc_vli(5'd2, 5'd6, 11'h003), 32'd20000, 32'd0, lat);
    total++; if (bus.vl !== 15'd16384) begin bad++; $display("FAIL m8_vl20000: got %0d want 16384", bus.vl); end
    total++; if (bus.out_rd_data !== 32'd16384) begin bad++; $display("FAIL m8_data20000: got %0d want 16384", bus.out_rd_data); end
    respond(1);
    send(enc_vli(5'd2, 5'd6, 11'h003), 32'h0001_0005, 32'd0, lat);
    total++; if (bus.vl !== 15'd16384) begin bad++; $display("FAIL wide_avl_vl: got %0d want 16384", bus.vl); end
    respond(0);
    send(enc_ivli(5'd3, 5'd31, 10'h008), 32'd0, 32'd0, lat);
    total++; if (bus.vl !== 15'd31) begin bad++; $display("FAIL ivli_vl: got %0d want 31", bus.vl); end
    total++; if (bus.vlmax !== 15'd1024) begin bad++; $display("FAIL ivli_vlmax: got %0d want 1024", bus.vlmax); end
    respond(0);
  endtask

  task automatic test_frac_vill();
    int lat;
    send(enc_vli(5'd3, 5'd0, 11'h017), 32'd5, 32'd0, lat);
    total++; if (bus.vl !== 15'd256) begin bad++; $display("FAIL mf2_vl: got %0d want 256", bus.vl); end
    total++; if (bus.vlmax !== 15'd256) begin bad++; $display("FAIL mf2_vlmax: got %0d want 256", bus.vlmax); end
    respond(0);
    send(enc_vli(5'd3, 5'd7, 11'h01D), 32'd9, 32'd0, lat);
    total++; if (bus.vtype !== VILL) begin bad++; $display("FAIL mf8_vtype: got %h want %h", bus.vtype, VILL); end
    total++; if (bus.vl !== 15'd0) begin bad++; $display("FAIL mf8_vl: got %0d want 0", bus.vl); end
    total++; if (bus.out_rd_data !== 32'd0) begin bad++; $display("FAIL mf8_data: got %0d want 0", bus.out_rd_data); end
    total++; if (bus.out_rd_we !== 1'b1) begin bad++; $display("FAIL mf8_we: got %b want 1", bus.out_rd_we); end
    respond(0);
    send(enc_vli(5'd1, 5'd5, 11'h010), 32'd60, 32'd0, lat);
    respond(0);
    send(enc_vl(5'd4, 5'd8, 5'd9), 32'd50, 32'h0000_0100, lat);
    total++; if (bus.vtype !== VILL) begin bad++; $display("FAIL resv_vtype: got %h want %h", bus.vtype, VILL); end
    total++; if (bus.vlmax !== 15'd0) begin bad++; $display("FAIL resv_vlmax: got %0d want 0", bus.vlmax); end
    respond(0);
    send(enc_vli(5'd1, 5'd5, 11'h010), 32'd60, 32'd0, lat);
    respond(0);
    send(enc_vli(5'd5, 5'd5, 11'h090), 32'd60, 32'd0, lat);
    total++; if (bus.vtype !== VILL) begin bad++; $display("FAIL vma_vtype: got %h want %h", bus.vtype, VILL); end
    total++; if (bus.vl !== 15'd0) begin bad++; $display("FAIL vma_vl: got %0d want 0", bus.vl); end
    respond(0);
  endtask

  task automatic test_keep_vl();
    int lat;
    send(enc_vli(5'd1, 5'd5, 11'h010), 32'd77, 32'd0, lat);
    respond(0);
    send(enc_vli(5'd0, 5'd0, 11'h008), 32'd0, 32'd0, lat);
    total++; if (bus.vtype !== VILL) begin bad++; $display("FAIL keep_bad_vtype: got %h want %h", bus.vtype, VILL); end
    total++; if (bus.vl !== 15'd0) begin bad++; $display("FAIL keep_bad_vl: got %0d want 0", bus.vl); end
    respond(0);
    send(enc_vli(5'd1, 5'd5, 11'h010), 32'd77, 32'd0, lat);
    respond(0);
    send(enc_vli(5'd0, 5'd0, 11'h019), 32'd0, 32'd0, lat);
    total++; if (bus.vl !== 15'd77) begin bad++; $display("FAIL keep_ok_vl: got %0d want 77", bus.vl); end
    total++; if (bus.vtype !== 32'h19) begin bad++; $display("FAIL keep_ok_vtype: got %h want 19", bus.vtype); end
    total++; if (bus.out_rd_we !== 1'b0) begin bad++; $display("FAIL keep_ok_we: got %b want 0", bus.out_rd_we); end
    respond(0);
  endtask

  task automatic test_non_cfg();
    int lat;
    send(32'h0020_80B3, 32'd3, 32'd4, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL noncfg_latency: got %0d want 2", lat); end
    total++; if (bus.out_rd_we !== 1'b0) begin bad++; $display("FAIL noncfg_we: got %b want 0", bus.out_rd_we); end
    total++; if (bus.vl !== 15'd77) begin bad++; $display("FAIL noncfg_vl: got %0d want 77", bus.vl); end
    total++; if (bus.vtype !== 32'h19) begin bad++; $display("FAIL noncfg_vtype: got %h want 19", bus.vtype); end
    respond(0);
    send({7'b1000001, 5'd9, 5'd8, 3'b111, 5'd4, 7'b1010111}, 32'd3, 32'd0, lat);
    total++; if (bus.out_rd_we !== 1'b0) begin bad++; $display("FAIL badf7_we: got %b want 0", bus.out_rd_we); end
    total++; if (bus.vlmax !== 15'd512) begin bad++; $display("FAIL badf7_vlmax: got %0d want 512", bus.vlmax); end
    respond(0);
  endtask

  task automatic test_backpressure();
    int lat;
    send(enc_vli(5'd6, 5'd5, 11'h000), 32'd300, 32'd0, lat);
    bus.in_valid = 1'b1; bus.insn = enc_vli(5'd6, 5'd5, 11'h000); bus.rs1_val = 32'd7;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d: got %b want 1", k, bus.out_valid); end
      total++; if (bus.out_rd_data !== 32'd300) begin bad++; $display("FAIL bp_data%0d: got %0d want 300", k, bus.out_rd_data); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d: got %b want 0", k, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    respond(0);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after: got %b want 1", bus.in_ready); end
    total++; if (bus.vl !== 15'd300) begin bad++; $display("FAIL bp_vl_after: got %0d want 300", bus.vl); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 150; it++) begin
      logic [31:0] i, a, b;
      logic [4:0]  rd, rs1;
      logic [10:0] z;
      int          kind, lat;
      rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rs1   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      z[2:0] = 3'($urandom_range(0, 7));
      z[5:3] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      z[6]   = 1'($urandom_range(0, 1));
      z[7]   = ($urandom_range(0, 7) == 0);
      z[10:8] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20000)) : $urandom;
      b = {($urandom_range(0, 15) == 0), 20'd0, z};
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: i = enc_vli(rd, rs1, z);
        4, 5:       i = enc_ivli(rd, rs1, z[9:0]);
        6, 7:       i = enc_vl(rd, rs1, 5'($urandom_range(0, 31)));
        8:          i = $urandom;
        default:    i = enc_vli(5'd0, 5'd0, z);
      endcase
      send(i, a, b, lat);
      total++; if (lat !== 2) begin bad++; $display("FAIL rnd%0d_latency: got %0d want 2", it, lat); end
      total++; if (bus.out_rd_we !== m_we) begin bad++; $display("FAIL rnd%0d_we: insn %h got %b want %b", it, i, bus.out_rd_we, m_we); end
      total++; if (bus.out_rd_addr !== i[11:7]) begin bad++; $display("FAIL rnd%0d_addr: got %0d want %0d", it, bus.out_rd_addr, i[11:7]); end
      if (m_cfg) begin
        total++; if (bus.out_rd_data !== m_data) begin bad++; $display("FAIL rnd%0d_data: insn %h got %0d want %0d", it, i, bus.out_rd_data, m_data); end
      end else begin
        total++; if (bus.out_rd_we !== 1'b0) begin bad++; $display("FAIL rnd%0d_noncfg_we: got %b want 0", it, bus.out_rd_we); end
      end
      total++; if (longint'(bus.vl) !== m_vl) begin bad++; $display("FAIL rnd%0d_vl: insn %h rs1 %h got %0d want %0d", it, i, a, bus.vl, m_vl); end
      total++; if (bus.vtype !== m_vtype) begin bad++; $display("FAIL rnd%0d_vtype: insn %h got %h want %h", it, i, bus.vtype, m_vtype); end
      total++; if (longint'(bus.vlmax) !== m_vlmax) begin bad++; $display("FAIL rnd%0d_vlmax: insn %h got %0d want %0d", it, i, bus.vlmax, m_vlmax); end
      respond($urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid();
    int lat, n;
    send(enc_vli(5'd1, 5'd5, 11'h010), 32'd99, 32'd0, lat);
    respond(0);
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    bus.in_valid = 1'b1; bus.insn = enc_vli(5'd1, 5'd5, 11'h003); bus.rs1_val = 32'd123;
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.vl !== 15'd0) begin bad++; $display("FAIL midrst_vl: got %0d want 0", bus.vl); end
    total++; if (bus.vtype !== VILL) begin bad++; $display("FAIL midrst_vtype: got %h want %h", bus.vtype, VILL); end
    total++; if (bus.vlmax !== 15'd0) begin bad++; $display("FAIL midrst_vlmax: got %0d want 0", bus.vlmax); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_dropped: got %b want 0", bus.out_valid); end
    send(enc_ivli(5'd7, 5'd9, 10'h010), 32'd0, 32'd0, lat);
    total++; if (bus.vl !== 15'd9) begin bad++; $display("FAIL midrst_resume_vl: got %0d want 9", bus.vl); end
    respond(0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.insn = 32'd0; bus.rs1_val = 32'd0; bus.rs2_val = 32'd0;
    bus.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_vsetvli();
    test_frac_vill();
    test_keep_vl();
    test_non_cfg();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
